// File: rtl/cmp_arbiter.sv
// Shared XLEN-bit subtract/compare unit arbitrated between two requesters with a registered response slot.
// Optional define CMP_ARB_FIXED_PRIO_EN: req0 always wins ties (no round-robin state).
module cmp_arbiter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [2:0]      req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [2:0]      req1_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic            rsp_taken,
  output logic            rsp_eq,
  output logic            rsp_lt,
  output logic            rsp_ltu,
  output logic            rsp_err
);

  localparam int unsigned SW = XLEN + 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t           state;
  logic            grant;
  logic            can_accept;
  logic            accept;
  logic [XLEN-1:0] a_sel;
  logic [XLEN-1:0] b_sel;
  logic [2:0]      op_sel;
  logic [SW-1:0]   diff;
  logic            eq_c;
  logic            lt_c;
  logic            ltu_c;
  logic            taken_c;
  logic            err_c;

  assign rsp_valid  = (state == FULL);
  assign can_accept = !rst && (!rsp_valid || rsp_ready);

`ifdef CMP_ARB_FIXED_PRIO_EN
  assign grant = !req0_valid;
`else
  logic last_grant;

  // On a tie, the requester that did not win last time goes next.
  assign grant = (req0_valid && req1_valid) ? ~last_grant : !req0_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end
`endif

  assign req0_ready = can_accept && req0_valid && !grant;
  assign req1_ready = can_accept && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign a_sel  = grant ? req1_a  : req0_a;
  assign b_sel  = grant ? req1_b  : req0_b;
  assign op_sel = grant ? req1_op : req0_op;

  // a - b as a + ~b + 1; the carry out is set exactly when a >= b unsigned.
  assign diff  = {1'b0, a_sel} + {1'b0, ~b_sel} + SW'(1);
  assign eq_c  = (diff[XLEN-1:0] == '0);
  assign ltu_c = !diff[XLEN];
  assign lt_c  = (a_sel[XLEN-1] != b_sel[XLEN-1]) ? a_sel[XLEN-1] : diff[XLEN-1];

  always_comb begin
    taken_c = 1'b0;
    err_c   = 1'b0;
    case (op_sel)
      3'b000:  taken_c = eq_c;
      3'b001:  taken_c = !eq_c;
      3'b100:  taken_c = lt_c;
      3'b101:  taken_c = !lt_c;
      3'b110:  taken_c = ltu_c;
      3'b111:  taken_c = !ltu_c;
      default: err_c   = 1'b1;
    endcase
  end

  // Response slot: load on acceptance, drain when consumed, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      rsp_id    <= 1'b0;
      rsp_taken <= 1'b0;
      rsp_eq    <= 1'b0;
      rsp_lt    <= 1'b0;
      rsp_ltu   <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      state     <= FULL;
      rsp_id    <= grant;
      rsp_taken <= taken_c;
      rsp_eq    <= eq_c;
      rsp_lt    <= lt_c;
      rsp_ltu   <= ltu_c;
      rsp_err   <= err_c;
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule
